// File: rtl/mux2_pkg.sv
// Shared definitions for the two-input round-robin mux arbiter.
// Holds the arbiter FSM state encoding.
package mux2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

endpackage

// File: rtl/mux2.sv
// Single-bit two-input multiplexer.
// s=0 selects a, s=1 selects b.
module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter with lock and a one-beat output slot.
// Accepted payload is selected through per-bit mux2 cells.
module mux2_rr_arbiter
    import mux2_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             lock_a,
    input  logic             lock_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready
);

    state_t           state;
    state_t           state_n;
    logic             last_b;
    logic             hist;
    logic             free;
    logic             acc_a;
    logic             acc_b;
    logic [WIDTH-1:0] mux_y;

    assign free  = !y_valid || y_ready;
    assign gnt_a = acc_a;
    assign gnt_b = acc_b;

    // A tie before any grant since reset goes to A.
    always_comb begin
        acc_a   = 1'b0;
        acc_b   = 1'b0;
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    if (hist && !last_b) acc_b = free;
                    else                 acc_a = free;
                end else begin
                    acc_a = req_a && free;
                    acc_b = req_b && free;
                end
            end
            OWN_A:   acc_a = req_a && free;
            OWN_B:   acc_b = req_b && free;
            default: ;
        endcase
        if (rst) begin
            acc_a = 1'b0;
            acc_b = 1'b0;
        end
        if (acc_a) begin
            state_n = lock_a ? OWN_A : IDLE;
        end else if (acc_b) begin
            state_n = lock_b ? OWN_B : IDLE;
        end else if (state == OWN_A && !lock_a) begin
            state_n = IDLE;
        end else if (state == OWN_B && !lock_b) begin
            state_n = IDLE;
        end else if (state != OWN_A && state != OWN_B) begin
            state_n = IDLE;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux2 u_mux (
            .a (data_a[i]),
            .b (data_b[i]),
            .s (acc_b),
            .y (mux_y[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b  <= 1'b0;
            hist    <= 1'b0;
            y_valid <= 1'b0;
            y_data  <= '0;
            sel     <= 1'b0;
        end else if (acc_a || acc_b) begin
            last_b  <= acc_b;
            hist    <= 1'b1;
            y_valid <= 1'b1;
            y_data  <= mux_y;
            sel     <= acc_b;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomised and directed bench for mux2_rr_arbiter (WIDTH=8).
// Expected values come from a transaction-level owner/turn model.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic       lock_a = 1'b0;
    logic       lock_b = 1'b0;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_ready = 1'b0;

    int errs = 0;
    int checks = 0;

    // model: owner 0=none 1=A 2=B; last -1=none 0=A 1=B
    int       m_owner;
    int       m_last;
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_sel;
    bit       eg_a;
    bit       eg_b;
    logic     ob_a;
    logic     ob_b;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req_a),
        .req_b   (req_b),
        .data_a  (data_a),
        .data_b  (data_b),
        .lock_a  (lock_a),
        .lock_b  (lock_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .sel     (sel),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready)
    );

    task automatic model_reset();
        m_owner = 0;
        m_last  = -1;
        m_valid = 0;
        m_data  = '0;
        m_sel   = 0;
    endtask

    // Drives one cycle, samples grants mid-cycle, advances the model.
    task automatic cycle(input bit ra, input bit rb, input bit la,
                         input bit lb, input bit [7:0] da,
                         input bit [7:0] db, input bit yr);
        bit free;
        req_a = ra; req_b = rb; lock_a = la; lock_b = lb;
        data_a = da; data_b = db; y_ready = yr;
        #1;
        free = !m_valid || yr;
        eg_a = 0;
        eg_b = 0;
        if (free) begin
            if (m_owner == 1) eg_a = ra;
            else if (m_owner == 2) eg_b = rb;
            else if (ra && rb) begin
                if (m_last == 0) eg_b = 1;
                else eg_a = 1;
            end else begin
                eg_a = ra;
                eg_b = rb;
            end
        end
        ob_a = gnt_a;
        ob_b = gnt_b;
        @(posedge clk);
        #1;
        if (eg_a || eg_b) begin
            m_valid = 1;
            m_data  = eg_b ? db : da;
            m_sel   = eg_b;
            m_last  = eg_b ? 1 : 0;
            m_owner = eg_a ? (la ? 1 : 0) : (lb ? 2 : 0);
        end else begin
            if (yr) m_valid = 0;
            if (m_owner == 1 && !la) m_owner = 0;
            if (m_owner == 2 && !lb) m_owner = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        y_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt_a, gnt_b} !== 2'b00) begin
            errs++;
            $display("FAIL reset_gnt got=%b exp=00", {gnt_a, gnt_b});
        end
        checks++;
        if ({y_valid, sel, y_data} !== 10'd0) begin
            errs++;
            $display("FAIL reset_out got=%b/%b/%h exp=0/0/00",
                     y_valid, sel, y_data);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 0, 8'($urandom), 8'($urandom), 1);
            checks++;
            if ({ob_a, ob_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errs++;
                $display("FAIL alt_order[%0d] got=%b exp=%b", i,
                         {ob_a, ob_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            checks++;
            if ({y_valid, sel, y_data} !== {m_valid, m_sel, m_data}) begin
                errs++;
                $display("FAIL alt_out[%0d] got=%b/%b/%h exp=%b/%b/%h", i,
                         y_valid, sel, y_data, m_valid, m_sel, m_data);
            end
        end
    endtask

    task automatic test_lock();
        int a_beats = 0;
        int b_early = 0;
        bit saw_b = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, a_beats < 3, 0, 8'($urandom), 8'($urandom), 1);
            checks++;
            if ({ob_a, ob_b} !== {eg_a, eg_b}) begin
                errs++;
                $display("FAIL lock_gnt[%0d] got=%b exp=%b", i,
                         {ob_a, ob_b}, {eg_a, eg_b});
            end
            if (ob_b && a_beats > 0 && a_beats < 3) b_early++;
            if (ob_b) saw_b = 1;
            if (eg_a) a_beats++;
        end
        checks++;
        if (b_early != 0 || !saw_b) begin
            errs++;
            $display("FAIL lock_block got early_b=%0d saw_b=%0d exp=0/1",
                     b_early, saw_b);
        end
    endtask

    task automatic test_stall();
        bit [10:0] held;
        cycle(1, 0, 0, 0, 8'($urandom), 8'($urandom), 1);
        held = {m_valid, m_sel, m_data};
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0, 8'($urandom), 8'($urandom), 0);
            checks++;
            if ({ob_a, ob_b, y_valid, sel, y_data} !== {2'b00, held[9:0]}) begin
                errs++;
                $display("FAIL stall[%0d] got=%b %b/%b/%h exp=00 %b/%b/%h",
                         i, {ob_a, ob_b}, y_valid, sel, y_data,
                         held[9], held[8], held[7:0]);
            end
        end
        cycle(1, 1, 0, 0, 8'h3c, 8'hc3, 1);
        checks++;
        if ({ob_a, ob_b, y_valid, sel, y_data} !==
            {eg_a, eg_b, 1'b1, m_sel, m_data}) begin
            errs++;
            $display("FAIL stall_resume got=%b %b/%b/%h exp=%b 1/%b/%h",
                     {ob_a, ob_b}, y_valid, sel, y_data,
                     {eg_a, eg_b}, m_sel, m_data);
        end
    endtask

    task automatic test_single_b();
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 8'($urandom), 8'($urandom), 1);
            checks++;
            if ({ob_a, ob_b, y_valid, sel, y_data} !==
                {2'b01, 1'b1, 1'b1, m_data}) begin
                errs++;
                $display("FAIL single_b[%0d] got=%b %b/%b/%h exp=01 1/1/%h",
                         i, {ob_a, ob_b}, y_valid, sel, y_data, m_data);
            end
        end
        // both request: turn must go to A after B was last
        cycle(1, 1, 0, 0, 8'h11, 8'h22, 1);
        checks++;
        if ({ob_a, ob_b} !== 2'b10) begin
            errs++;
            $display("FAIL single_b_turn got=%b exp=10", {ob_a, ob_b});
        end
    endtask

    task automatic test_mid_reset();
        cycle(0, 1, 0, 0, 8'h00, 8'h9e, 1);
        #2;
        req_a = 1'b1;
        req_b = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt_a, gnt_b, y_valid, sel, y_data} !== 12'd0) begin
            errs++;
            $display("FAIL mid_reset got=%b %b/%b/%h exp=00 0/0/00",
                     {gnt_a, gnt_b}, y_valid, sel, y_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1, 1, 0, 0, 8'h44, 8'h55, 1);
        checks++;
        if ({ob_a, ob_b, y_valid, sel, y_data} !== {2'b10, 2'b10, 8'h44}) begin
            errs++;
            $display("FAIL post_reset got=%b %b/%b/%h exp=10 1/0/44",
                     {ob_a, ob_b}, y_valid, sel, y_data);
        end
    endtask

    task automatic test_pattern();
        bit [7:0] seq [3] = '{8'hA5, 8'h5A, 8'hA5};
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 8'hA5, 8'h5A, 1);
            checks++;
            if (y_data !== seq[i] || y_valid !== 1'b1) begin
                errs++;
                $display("FAIL pattern[%0d] got=%b/%h exp=1/%h", i,
                         y_valid, y_data, seq[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(3) != 0, $urandom_range(3) != 0,
                  $urandom_range(2) == 0, $urandom_range(2) == 0,
                  8'($urandom), 8'($urandom), $urandom_range(3) != 0);
            checks++;
            if ({ob_a, ob_b} !== {eg_a, eg_b}) begin
                errs++;
                $display("FAIL rand_gnt[%0d] got=%b exp=%b", i,
                         {ob_a, ob_b}, {eg_a, eg_b});
            end
            checks++;
            if ({y_valid, sel, y_data} !== {m_valid, m_sel, m_data}) begin
                errs++;
                $display("FAIL rand_out[%0d] got=%b/%b/%h exp=%b/%b/%h", i,
                         y_valid, sel, y_data, m_valid, m_sel, m_data);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alternate();
        test_lock();
        test_stall();
        test_single_b();
        test_mid_reset();
        test_pattern();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
